// File: rtl/freq_meas_pkg.sv
// freq_meas_pkg: shared state encoding and BCD digit type for the gated frequency meter.
// Rev 1.0
`default_nettype none

package freq_meas_pkg;

   typedef enum logic [1:0] {
      WARMUP = 2'd0,
      CLEAR  = 2'd1,
      GATE   = 2'd2,
      LATCH  = 2'd3
   } meas_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

endpackage

`default_nettype wire

// File: rtl/bcd_chain.sv
// bcd_chain: cascaded BCD counter with synchronous clear, increment enable and top carry out.
// Rev 1.0
`default_nettype none

module bcd_chain
   import freq_meas_pkg::*;
#(
   parameter int DIGITS = 6
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_clear,
   input  logic                  i_inc,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_carry
);

   logic [DIGITS-1:0] w_nine;
   logic [DIGITS:0]   w_en;

   // Each digit advances only when every lower digit is wrapping in the same cycle.
   always_comb begin
      w_en    = '0;
      w_en[0] = i_inc;
      for (int d = 1; d <= DIGITS; d++) begin
         w_en[d] = w_en[d-1] && w_nine[d-1];
      end
   end

   generate
      for (genvar d = 0; d < DIGITS; d++) begin : g_digit
         bcd_digit_t r_digit;

         always_ff @(posedge clk) begin
            if (rst || i_clear) begin
               r_digit <= '0;
            end else if (w_en[d]) begin
               r_digit <= (r_digit == BCD_MAX) ? 4'd0 : r_digit + 4'd1;
            end
         end

         assign w_nine[d]        = (r_digit == BCD_MAX);
         assign o_bcd[4*d +: 4]  = r_digit;
      end
   endgenerate

   assign o_carry = w_en[DIGITS];

endmodule

`default_nettype wire

// File: rtl/freq_gate_measure.sv
// freq_gate_measure: counts synchronised rising edges of signal_in over a fixed gate window
// and hands the latched BCD result downstream over valid/ready.  Rev 1.0
`default_nettype none

module freq_gate_measure
   import freq_meas_pkg::*;
#(
   parameter int DIGITS      = 6,
   parameter int GATE_CYCLES = 1_000_000,
   parameter int SYNC_STAGES = 2
)
(
   input  logic                  clk_in,
   input  logic                  reset_in,
   input  logic                  signal_in,
   output logic [4*DIGITS-1:0]   result_out,
   output logic                  overflow_out,
   output logic                  valid_out,
   input  logic                  ready_in,
   output logic                  overrun_out,
   output logic                  gate_active_out
);

   localparam int                  TIMER_W    = $clog2(GATE_CYCLES);
   localparam int                  WARM_W     = $clog2(SYNC_STAGES + 1);
   localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);
   localparam logic [WARM_W-1:0]   WARM_LAST  = WARM_W'(SYNC_STAGES);

   meas_state_t               r_state;
   logic [WARM_W-1:0]         r_warm;
   logic [TIMER_W-1:0]        r_timer;
   logic [SYNC_STAGES-1:0]    r_sync;
   logic                      r_prev;
   logic                      r_sticky_ovf;
   logic                      r_gate_active;
   logic [4*DIGITS-1:0]       r_result;
   logic                      r_overflow;
   logic                      r_valid;
   logic                      r_overrun;

   logic                      w_edge;
   logic                      w_inc;
   logic                      w_clear;
   logic [4*DIGITS-1:0]       w_chain;
   logic                      w_carry;

   assign w_edge  = r_sync[SYNC_STAGES-1] && !r_prev;
   assign w_inc   = (r_state == GATE) && w_edge;
   assign w_clear = (r_state == CLEAR);

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], signal_in};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   bcd_chain #(
      .DIGITS  (DIGITS)
   ) u_chain (
      .clk     (clk_in),
      .rst     (reset_in),
      .i_clear (w_clear),
      .i_inc   (w_inc),
      .o_bcd   (w_chain),
      .o_carry (w_carry)
   );

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_state       <= WARMUP;
         r_warm        <= '0;
         r_timer       <= '0;
         r_gate_active <= 1'b0;
      end else begin
         case (r_state)
            WARMUP: begin
               if (r_warm == WARM_LAST) begin
                  r_state <= CLEAR;
               end else begin
                  r_warm <= r_warm + WARM_W'(1);
               end
            end
            CLEAR: begin
               r_timer       <= '0;
               r_state       <= GATE;
               r_gate_active <= 1'b1;
            end
            GATE: begin
               if (r_timer == TIMER_LAST) begin
                  r_state       <= LATCH;
                  r_gate_active <= 1'b0;
               end else begin
                  r_timer <= r_timer + TIMER_W'(1);
               end
            end
            LATCH: begin
               r_state <= CLEAR;
            end
            default: begin
               r_state <= WARMUP;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in || w_clear) begin
         r_sticky_ovf <= 1'b0;
      end else if (w_carry) begin
         r_sticky_ovf <= 1'b1;
      end
   end

   // A LATCH coinciding with a handshake keeps valid high with the fresh result.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_result   <= '0;
         r_overflow <= 1'b0;
         r_valid    <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (r_state == LATCH) begin
            r_result   <= w_chain;
            r_overflow <= r_sticky_ovf;
            r_valid    <= 1'b1;
            r_overrun  <= r_valid && !ready_in;
         end else if (r_valid && ready_in) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign result_out      = r_result;
   assign overflow_out    = r_overflow;
   assign valid_out       = r_valid;
   assign overrun_out     = r_overrun;
   assign gate_active_out = r_gate_active;

endmodule

`default_nettype wire

// File: tb/tb_freq_gate_measure.sv
// tb_freq_gate_measure: directed scenarios for the gated frequency meter.
// Rev 1.0
`default_nettype none

module tb_freq_gate_measure;

   localparam int DIGITS   = 3;
   localparam int GATE     = 100;
   localparam int GATE_OVF = 2500;
   localparam int SYNC     = 2;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, sig, rdy;
   logic [11:0] result;
   logic        ovf, valid, overrun, gact;

   logic        rst_o, sig_o, rdy_o;
   logic [11:0] result_o;
   logic        ovf_o, valid_o, overrun_o, gact_o;

   int checks = 0;
   int errors = 0;
   int mode   = 0;
   int phase  = 0;

   freq_gate_measure #(.DIGITS(DIGITS), .GATE_CYCLES(GATE), .SYNC_STAGES(SYNC)) dut (
      .clk_in(clk), .reset_in(rst), .signal_in(sig), .result_out(result),
      .overflow_out(ovf), .valid_out(valid), .ready_in(rdy),
      .overrun_out(overrun), .gate_active_out(gact)
   );

   freq_gate_measure #(.DIGITS(DIGITS), .GATE_CYCLES(GATE_OVF), .SYNC_STAGES(SYNC)) dut_ovf (
      .clk_in(clk), .reset_in(rst_o), .signal_in(sig_o), .result_out(result_o),
      .overflow_out(ovf_o), .valid_out(valid_o), .ready_in(rdy_o),
      .overrun_out(overrun_o), .gate_active_out(gact_o)
   );

   // mode: 0 low, 1 high, 2 square period 4, 3 toggle every cycle
   initial begin
      sig   = 1'b0;
      sig_o = 1'b0;
      forever begin
         @(negedge clk);
         phase++;
         sig_o = ~sig_o;
         case (mode)
            0:       sig = 1'b0;
            1:       sig = 1'b1;
            2:       sig = phase[1];
            3:       sig = ~sig;
            default: sig = 1'b0;
         endcase
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic wait_valid(input int limit, output int n);
      n = 0;
      @(posedge clk); #1;
      n = 1;
      while (!valid && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      if (!valid) begin
         checks++; errors++;
         $display("FAIL wait_valid: valid_out still 0 after %0d cycles", limit);
      end
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (result !== 12'h000) begin errors++; $display("FAIL reset_result: got %h expected 000", result); end
      checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_overflow: got %b expected 0", ovf); end
      checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
      checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
      checks++; if (gact !== 1'b0)      begin errors++; $display("FAIL reset_gate_active: got %b expected 0", gact); end
   endtask

   task automatic test_square();
      int n;
      mode = 2; rdy = 1'b1;
      do_reset();
      wait_valid(300, n);
      checks++; if (n != 105)          begin errors++; $display("FAIL square_first_latency: got %0d expected 105", n); end
      checks++; if (result !== 12'h025) begin errors++; $display("FAIL square_result1: got %h expected 025", result); end
      checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL square_overflow: got %b expected 0", ovf); end
      checks++; if (gact !== 1'b0)      begin errors++; $display("FAIL square_gate_in_clear: got %b expected 0", gact); end
      @(posedge clk); #1;
      checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL square_valid_one_cycle: got %b expected 0", valid); end
      checks++; if (gact !== 1'b1)      begin errors++; $display("FAIL square_gate_active: got %b expected 1", gact); end
      wait_valid(300, n);
      checks++; if (n != 101)          begin errors++; $display("FAIL square_period: got %0d expected 101", n); end
      checks++; if (result !== 12'h025) begin errors++; $display("FAIL square_result2: got %h expected 025", result); end
   endtask

   task automatic test_toggle();
      int n;
      mode = 3; rdy = 1'b1;
      do_reset();
      wait_valid(300, n);
      checks++; if (n != 105)          begin errors++; $display("FAIL toggle_latency: got %0d expected 105", n); end
      checks++; if (result !== 12'h050) begin errors++; $display("FAIL toggle_result1: got %h expected 050", result); end
      checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL toggle_overflow: got %b expected 0", ovf); end
      wait_valid(300, n);
      checks++; if (n != 102)          begin errors++; $display("FAIL toggle_period: got %0d expected 102", n); end
      checks++; if (result !== 12'h050) begin errors++; $display("FAIL toggle_result2: got %h expected 050", result); end
   endtask

   task automatic test_overrun();
      int n, k, nov;
      mode = 0; rdy = 1'b0;
      do_reset();
      wait_valid(300, n);
      checks++; if (result !== 12'h000) begin errors++; $display("FAIL overrun_first_result: got %h expected 000", result); end
      checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL overrun_first_latch: got %b expected 0", overrun); end
      mode = 3;
      k = 0; nov = 0;
      while (result === 12'h000 && k < 200) begin
         @(posedge clk); #1;
         k++;
         if (overrun === 1'b1) nov++;
      end
      checks++; if (k != 102)           begin errors++; $display("FAIL overrun_second_latch_time: got %0d expected 102", k); end
      checks++; if (result !== 12'h050) begin errors++; $display("FAIL overrun_second_result: got %h expected 050", result); end
      checks++; if (overrun !== 1'b1)   begin errors++; $display("FAIL overrun_pulse: got %b expected 1", overrun); end
      rdy = 1'b1;
      @(posedge clk); #1;
      if (overrun === 1'b1) nov++;
      checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL overrun_valid_falls: got %b expected 0", valid); end
      checks++; if (nov != 1)           begin errors++; $display("FAIL overrun_pulse_count: got %0d expected 1", nov); end
   endtask

   task automatic test_latch_handshake();
      int n;
      mode = 0; rdy = 1'b0;
      do_reset();
      wait_valid(300, n);
      mode = 3;
      repeat (101) @(posedge clk);
      #1;
      checks++; if (valid !== 1'b1 || result !== 12'h000) begin
         errors++; $display("FAIL hs_hold: got valid=%b result=%h expected valid=1 result=000", valid, result);
      end
      rdy = 1'b1;
      @(posedge clk); #1;
      checks++; if (valid !== 1'b1)     begin errors++; $display("FAIL hs_latch_valid: got %b expected 1", valid); end
      checks++; if (result !== 12'h050) begin errors++; $display("FAIL hs_latch_result: got %h expected 050", result); end
      checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL hs_latch_overrun: got %b expected 0", overrun); end
      @(posedge clk); #1;
      checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL hs_valid_falls: got %b expected 0", valid); end
   endtask

   task automatic test_reset_mid_gate();
      int n;
      mode = 2; rdy = 1'b1;
      do_reset();
      wait_valid(300, n);
      checks++; if (result !== 12'h025) begin errors++; $display("FAIL midrst_pre_result: got %h expected 025", result); end
      repeat (44) @(posedge clk);
      #1;
      mode = 1;
      checks++; if (gact !== 1'b1)      begin errors++; $display("FAIL midrst_gate_active: got %b expected 1", gact); end
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (valid !== 1'b0 || gact !== 1'b0) begin
         errors++; $display("FAIL midrst_outputs: got valid=%b gate=%b expected 0 0", valid, gact);
      end
      rst = 1'b0;
      wait_valid(300, n);
      checks++; if (n != 105)          begin errors++; $display("FAIL midrst_latency: got %0d expected 105", n); end
      checks++; if (result !== 12'h000) begin errors++; $display("FAIL midrst_result: got %h expected 000", result); end
      checks++; if (ovf !== 1'b0)       begin errors++; $display("FAIL midrst_overflow: got %b expected 0", ovf); end
   endtask

   task automatic test_overflow();
      int n;
      @(posedge clk); #1;
      rst_o = 1'b1;
      @(posedge clk); #1;
      rst_o = 1'b0;
      n = 0;
      @(posedge clk); #1;
      n = 1;
      while (!valid_o && n < 2700) begin
         @(posedge clk); #1;
         n++;
      end
      checks++; if (n != 2505)            begin errors++; $display("FAIL ovf_latency: got %0d expected 2505", n); end
      checks++; if (result_o !== 12'h250) begin errors++; $display("FAIL ovf_result: got %h expected 250", result_o); end
      checks++; if (ovf_o !== 1'b1)       begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf_o); end
   endtask

   initial begin
      rst   = 1'b1;
      rdy   = 1'b0;
      rst_o = 1'b1;
      rdy_o = 1'b1;
      test_reset();
      test_square();
      test_toggle();
      test_overrun();
      test_latch_handshake();
      test_reset_mid_gate();
      test_overflow();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
